// File: rtl/rvv_group_sequencer.sv
// rvv_group_sequencer: vsetvl state plus LMUL group expansion of one vector ALU
// instruction into registered, tail-masked per-register beats with valid/ready.

// One byte lane: works out whether this byte of the current beat is a body
// element (index < vl) and zeroes both operand bytes when it is tail.
module rvv_seq_lane #(
   parameter int IDX   = 0,
   parameter int VLEN  = 64,
   parameter int AVL_W = 8
) (
   input  logic [2:0]       i_b,
   input  logic [2:0]       i_sew,
   input  logic [AVL_W-1:0] i_vl,
   input  logic [7:0]       i_a,
   input  logic [7:0]       i_bb,
   output logic             o_be,
   output logic [7:0]       o_a,
   output logic [7:0]       o_b
);
   logic [31:0] w_epr;
   logic [31:0] w_e;

   // global element index = beat * elements-per-register + element-in-register
   always_comb begin
      w_epr = 32'(VLEN / 8) >> i_sew;
      w_e   = (w_epr * 32'(i_b)) + (32'(IDX) >> i_sew);
      o_be  = (w_e < 32'(i_vl));
      o_a   = o_be ? i_a  : 8'h00;
      o_b   = o_be ? i_bb : 8'h00;
   end
endmodule

module rvv_group_sequencer #(
   parameter int VLEN  = 64,
   parameter int ELEN  = 64,
   parameter int AVL_W = 8,
   parameter int XLEN  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [2:0]           cfg_sew,
   input  logic [2:0]           cfg_lmul,
   input  logic [AVL_W-1:0]     cfg_avl,
   output logic [AVL_W-1:0]     vl,
   output logic [6:0]           vtype,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           in_op,
   input  logic [4:0]           in_vs1,
   input  logic [4:0]           in_vs2,
   input  logic [4:0]           in_vd,
   input  logic [XLEN-1:0]      in_scalar,
   output logic [4:0]           rf_raA,
   output logic [4:0]           rf_raB,
   input  logic [VLEN-1:0]      rf_rdA,
   input  logic [VLEN-1:0]      rf_rdB,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [VLEN-1:0]      out_opA,
   output logic [VLEN-1:0]      out_opB,
   output logic [XLEN-1:0]      out_scalar,
   output logic [3:0]           out_op,
   output logic [2:0]           out_sew,
   output logic [4:0]           out_wa,
   output logic [VLEN/8-1:0]    out_be,
   output logic                 out_last,
   output logic                 illegal
);
   localparam int NB = VLEN / 8;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t r_state, w_state_nxt;

   // architectural vl/vtype
   logic [AVL_W-1:0] r_vl;
   logic             r_vill;
   logic [2:0]       r_sew, r_lmul;

   // in-flight instruction snapshot (immune to later vsetvl)
   logic [3:0]       r_op;
   logic [XLEN-1:0]  r_scalar;
   logic [4:0]       r_vs1, r_vs2, r_vd;
   logic [AVL_W-1:0] r_ivl;
   logic [2:0]       r_isew, r_ilmul;
   logic [2:0]       r_b;

   // output beat register
   logic             r_out_valid;
   logic [VLEN-1:0]  r_out_opA, r_out_opB;
   logic [XLEN-1:0]  r_out_scalar;
   logic [3:0]       r_out_op;
   logic [2:0]       r_out_sew;
   logic [4:0]       r_out_wa;
   logic [NB-1:0]    r_out_be;
   logic             r_out_last;
   logic             r_illegal;

   logic [31:0]      w_sew_bits, w_vlmax;
   logic             w_cfg_bad, w_cfg_fire;
   logic [AVL_W-1:0] w_cfg_vl;
   logic [4:0]       w_lmul_mask;
   logic             w_misalign, w_in_fire, w_in_illegal, w_in_go;
   logic             w_last_beat, w_load;
   logic [NB-1:0]           w_be;
   logic [NB-1:0][7:0]      w_opA, w_opB;

   assign cfg_ready = (r_state == S_IDLE);
   assign in_ready  = (r_state == S_IDLE) && !cfg_valid;
   assign rf_raA    = r_vs1 + {2'b00, r_b};
   assign rf_raB    = r_vs2 + {2'b00, r_b};

   assign vl         = r_vl;
   assign vtype      = {r_vill, r_sew, r_lmul};
   assign out_valid  = r_out_valid;
   assign out_opA    = r_out_opA;
   assign out_opB    = r_out_opB;
   assign out_scalar = r_out_scalar;
   assign out_op     = r_out_op;
   assign out_sew    = r_out_sew;
   assign out_wa     = r_out_wa;
   assign out_be     = r_out_be;
   assign out_last   = r_out_last;
   assign illegal    = r_illegal;

   // vsetvl decode: 32-bit math so VLMAX up to 512 elements never overflows
   always_comb begin
      w_cfg_fire = cfg_valid && (r_state == S_IDLE);
      w_sew_bits = 32'd8 << cfg_sew;
      w_cfg_bad  = (cfg_sew > 3'd3) || (w_sew_bits > 32'(ELEN)) || (cfg_lmul > 3'd3);
      w_vlmax    = (32'(VLEN) >> (32'd3 + 32'(cfg_sew))) << cfg_lmul;
      w_cfg_vl   = (32'(cfg_avl) < w_vlmax) ? cfg_avl : w_vlmax[AVL_W-1:0];
   end

   // instruction legality and beat sequencing conditions
   always_comb begin
      w_lmul_mask  = (5'd1 << r_lmul) - 5'd1;
      w_misalign   = |((in_vs1 | in_vs2 | in_vd) & w_lmul_mask);
      w_in_fire    = in_valid && in_ready;
      w_in_illegal = r_vill || w_misalign;
      w_in_go      = w_in_fire && !w_in_illegal && (r_vl != '0);
      w_last_beat  = ({1'b0, r_b} == ((4'd1 << r_ilmul) - 4'd1));
      w_load       = (r_state == S_ISSUE) && (!r_out_valid || out_ready);
   end

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         rvv_seq_lane #(.IDX(gi), .VLEN(VLEN), .AVL_W(AVL_W)) u_lane (
            .i_b  (r_b),
            .i_sew(r_isew),
            .i_vl (r_ivl),
            .i_a  (rf_rdA[8*gi +: 8]),
            .i_bb (rf_rdB[8*gi +: 8]),
            .o_be (w_be[gi]),
            .o_a  (w_opA[gi]),
            .o_b  (w_opB[gi])
         );
      end
   endgenerate

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // FSM next state: IDLE -> ISSUE on a legal non-empty group, DRAIN holds the last beat
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_in_go) w_state_nxt = S_ISSUE;
         S_ISSUE: if (w_load && w_last_beat) w_state_nxt = S_DRAIN;
         S_DRAIN: if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // vl/vtype update on vsetvl
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_vl   <= '0;
         r_vill <= 1'b1;
         r_sew  <= 3'd0;
         r_lmul <= 3'd0;
      end else if (w_cfg_fire) begin
         if (w_cfg_bad) begin
            r_vl   <= '0;
            r_vill <= 1'b1;
            r_sew  <= 3'd0;
            r_lmul <= 3'd0;
         end else begin
            r_vl   <= w_cfg_vl;
            r_vill <= 1'b0;
            r_sew  <= cfg_sew;
            r_lmul <= cfg_lmul;
         end
      end
   end

   // instruction snapshot and beat counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_op     <= 4'd0;
         r_scalar <= '0;
         r_vs1    <= 5'd0;
         r_vs2    <= 5'd0;
         r_vd     <= 5'd0;
         r_ivl    <= '0;
         r_isew   <= 3'd0;
         r_ilmul  <= 3'd0;
         r_b      <= 3'd0;
      end else if (w_in_go) begin
         r_op     <= in_op;
         r_scalar <= in_scalar;
         r_vs1    <= in_vs1;
         r_vs2    <= in_vs2;
         r_vd     <= in_vd;
         r_ivl    <= r_vl;
         r_isew   <= r_sew;
         r_ilmul  <= r_lmul;
         r_b      <= 3'd0;
      end else if (w_load) begin
         r_b      <= r_b + 3'd1;
      end
   end

   // output beat register: loads a new beat when empty or being consumed
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_out_valid  <= 1'b0;
         r_out_opA    <= '0;
         r_out_opB    <= '0;
         r_out_scalar <= '0;
         r_out_op     <= 4'd0;
         r_out_sew    <= 3'd0;
         r_out_wa     <= 5'd0;
         r_out_be     <= '0;
         r_out_last   <= 1'b0;
      end else if (w_load) begin
         r_out_valid  <= 1'b1;
         r_out_opA    <= w_opA;
         r_out_opB    <= w_opB;
         r_out_scalar <= r_scalar;
         r_out_op     <= r_op;
         r_out_sew    <= r_isew;
         r_out_wa     <= r_vd + {2'b00, r_b};
         r_out_be     <= w_be;
         r_out_last   <= w_last_beat;
      end else if ((r_state == S_DRAIN) && out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   // one-cycle pulse for a dropped instruction
   always_ff @(posedge clk) begin
      if (!rst) r_illegal <= 1'b0;
      else      r_illegal <= w_in_fire && w_in_illegal;
   end
endmodule

// File: tb/tb_rvv_group_sequencer.sv
// Scoreboard bench for rvv_group_sequencer (VLEN=64): directed vectors push
// expected beats / illegal pulses; a monitor pops and compares on handshakes.
module tb_rvv_group_sequencer;
   localparam int VLEN = 64, ELEN = 64, AVL_W = 8, XLEN = 32, NB = VLEN / 8;

   logic             clk, rst, cfg_valid, cfg_ready;
   logic [2:0]       cfg_sew, cfg_lmul;
   logic [AVL_W-1:0] cfg_avl, vl;
   logic [6:0]       vtype;
   logic             in_valid, in_ready;
   logic [3:0]       in_op;
   logic [4:0]       in_vs1, in_vs2, in_vd;
   logic [XLEN-1:0]  in_scalar;
   logic [4:0]       rf_raA, rf_raB;
   logic [VLEN-1:0]  rf_rdA, rf_rdB;
   logic             out_valid, out_ready;
   logic [VLEN-1:0]  out_opA, out_opB;
   logic [XLEN-1:0]  out_scalar;
   logic [3:0]       out_op;
   logic [2:0]       out_sew;
   logic [4:0]       out_wa;
   logic [NB-1:0]    out_be;
   logic             out_last, illegal;

   typedef struct {
      logic [4:0]      wa;
      logic [NB-1:0]   be;
      logic            last;
      logic [VLEN-1:0] opA, opB;
      logic [3:0]      op;
      logic [XLEN-1:0] scalar;
      logic [2:0]      sew;
   } beat_t;

   beat_t exp_q[$];
   bit    ill_q[$];
   int    n_checks = 0, n_fail = 0;
   int    ready_mode = 0;

   rvv_group_sequencer #(.VLEN(VLEN), .ELEN(ELEN), .AVL_W(AVL_W), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_sew(cfg_sew), .cfg_lmul(cfg_lmul), .cfg_avl(cfg_avl), .vl(vl), .vtype(vtype),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_vs1(in_vs1),
      .in_vs2(in_vs2), .in_vd(in_vd), .in_scalar(in_scalar), .rf_raA(rf_raA),
      .rf_raB(rf_raB), .rf_rdA(rf_rdA), .rf_rdB(rf_rdB), .out_valid(out_valid),
      .out_ready(out_ready), .out_opA(out_opA), .out_opB(out_opB),
      .out_scalar(out_scalar), .out_op(out_op), .out_sew(out_sew), .out_wa(out_wa),
      .out_be(out_be), .out_last(out_last), .illegal(illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // register file model: byte k of register a is {k,a} (B side inverted)
   function automatic logic [VLEN-1:0] rf_val(input logic [4:0] a, input bit inv);
      logic [VLEN-1:0] v;
      logic [2:0]      kk;
      v = '0;
      for (int k = 0; k < NB; k++) begin
         kk = 3'(k);
         v[8*k +: 8] = inv ? ~{kk, a} : {kk, a};
      end
      return v;
   endfunction

   function automatic logic [VLEN-1:0] bemask(input logic [NB-1:0] be);
      logic [VLEN-1:0] m;
      for (int k = 0; k < NB; k++) m[8*k +: 8] = be[k] ? 8'hFF : 8'h00;
      return m;
   endfunction

   function automatic logic [255:0] snap();
      return 256'({out_opA, out_opB, out_scalar, out_op, out_sew, out_wa, out_be, out_last});
   endfunction

   assign rf_rdA = rf_val(rf_raA, 1'b0);
   assign rf_rdB = rf_val(rf_raB, 1'b1);

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_beat(input logic [4:0] wa, input logic [NB-1:0] be, input logic last,
                            input logic [4:0] ra, input logic [4:0] rb, input logic [3:0] op,
                            input logic [XLEN-1:0] sc, input logic [2:0] sew);
      beat_t e;
      e.wa = wa; e.be = be; e.last = last; e.op = op; e.scalar = sc; e.sew = sew;
      e.opA = rf_val(ra, 1'b0) & bemask(be);
      e.opB = rf_val(rb, 1'b1) & bemask(be);
      exp_q.push_back(e);
   endtask

   // called at posedge+1; leaves the bench at posedge+1 after the config edge
   task automatic do_cfg(input logic [2:0] s, input logic [2:0] l, input logic [AVL_W-1:0] a);
      int t = 0;
      while (!cfg_ready && t < 50) begin @(posedge clk); #1; t++; end
      check("cfg_ready_wait", 256'(cfg_ready), 256'(1));
      cfg_valid = 1'b1; cfg_sew = s; cfg_lmul = l; cfg_avl = a;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
   endtask

   // called at posedge+1; returns at posedge+1 just after the accept edge
   task automatic do_instr(input logic [3:0] op, input logic [4:0] v1, input logic [4:0] v2,
                           input logic [4:0] vd, input logic [XLEN-1:0] sc);
      int t = 0;
      while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
      check("in_ready_wait", 256'(in_ready), 256'(1));
      in_valid = 1'b1; in_op = op; in_vs1 = v1; in_vs2 = v2; in_vd = vd; in_scalar = sc;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (!(cfg_ready && !out_valid && exp_q.size() == 0) && t < 200) begin
         @(posedge clk); #1; t++;
      end
      check("idle_wait", 256'(cfg_ready && !out_valid && exp_q.size() == 0), 256'(1));
   endtask

   // downstream ready: always, 1,0,0,1 pattern, or held low
   initial begin
      int pi = 0;
      logic [3:0] pat;
      pat = 4'b1001;
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #2;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       begin out_ready = pat[pi]; pi = (pi + 1) % 4; end
            default: out_ready = 1'b0;
         endcase
      end
   end

   // monitor: pops expectations on handshakes/pulses, checks stall stability
   initial begin
      bit             have_prev = 0;
      logic [255:0]   prev = '0;
      beat_t          e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            have_prev = 0;
         end else begin
            if (have_prev) begin
               check("stall_valid_held", 256'(out_valid), 256'(1));
               if (out_valid) check("stall_outputs_held", snap(), prev);
            end
            if (illegal) begin
               check("illegal_expected", 256'(ill_q.size() != 0), 256'(1));
               if (ill_q.size() != 0) void'(ill_q.pop_front());
            end
            if (out_valid && out_ready) begin
               check("beat_expected", 256'(exp_q.size() != 0), 256'(1));
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("beat_wa",     256'(out_wa),     256'(e.wa));
                  check("beat_be",     256'(out_be),     256'(e.be));
                  check("beat_last",   256'(out_last),   256'(e.last));
                  check("beat_opA",    256'(out_opA),    256'(e.opA));
                  check("beat_opB",    256'(out_opB),    256'(e.opB));
                  check("beat_op",     256'(out_op),     256'(e.op));
                  check("beat_scalar", 256'(out_scalar), 256'(e.scalar));
                  check("beat_sew",    256'(out_sew),    256'(e.sew));
               end
            end
            have_prev = out_valid && !out_ready;
            prev = snap();
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      rst = 1'b0; cfg_valid = 1'b0; cfg_sew = 3'd0; cfg_lmul = 3'd0; cfg_avl = '0;
      in_valid = 1'b0; in_op = 4'd0; in_vs1 = 5'd0; in_vs2 = 5'd0; in_vd = 5'd0; in_scalar = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 256'(out_valid), 256'(0));
      check("rst_vl",        256'(vl),        256'(0));
      check("rst_vtype",     256'(vtype),     256'(7'h40));
      check("rst_illegal",   256'(illegal),   256'(0));
      check("rst_cfg_ready", 256'(cfg_ready), 256'(1));
      check("rst_out_be",    256'(out_be),    256'(0));
      rst = 1'b1;
      @(posedge clk); #1;

      // instruction while vill=1 is dropped
      ill_q.push_back(1'b1);
      do_instr(4'h1, 5'd0, 5'd0, 5'd0, 32'h1);
      check("t1_illegal_pulse", 256'(illegal), 256'(1));
      @(posedge clk); #1;
      check("t1_illegal_clear", 256'(illegal),   256'(0));
      check("t1_no_beat",       256'(out_valid), 256'(0));
      check("t1_vl",            256'(vl),        256'(0));
      check("t1_vtype",         256'(vtype),     256'(7'h40));

      // SEW=16, LMUL=2, avl=5: beat1 keeps only element 4
      do_cfg(3'd1, 3'd1, 8'd5);
      check("t2_vl",    256'(vl),    256'(5));
      check("t2_vtype", 256'(vtype), 256'(7'h09));
      push_beat(5'd6, 8'hFF, 1'b0, 5'd2, 5'd4, 4'h2, 32'hDEADBEEF, 3'd1);
      push_beat(5'd7, 8'h03, 1'b1, 5'd3, 5'd5, 4'h2, 32'hDEADBEEF, 3'd1);
      do_instr(4'h2, 5'd2, 5'd4, 5'd6, 32'hDEADBEEF);
      check("t2_not_yet_valid", 256'(out_valid), 256'(0));
      check("t2_raA_b0",        256'(rf_raA),    256'(2));
      check("t2_raB_b0",        256'(rf_raB),    256'(4));
      @(posedge clk); #1;
      check("t2_first_valid",   256'(out_valid), 256'(1));
      check("t2_raA_b1",        256'(rf_raA),    256'(3));
      check("t2_raB_b1",        256'(rf_raB),    256'(5));
      wait_idle();

      // misaligned vs1 under LMUL=2
      ill_q.push_back(1'b1);
      do_instr(4'h2, 5'd3, 5'd4, 5'd6, 32'h2);
      check("t3_illegal_pulse", 256'(illegal),  256'(1));
      check("t3_in_ready",      256'(in_ready), 256'(1));
      @(posedge clk); #1;
      check("t3_no_beat",       256'(out_valid), 256'(0));
      wait_idle();

      // vl clamping and vill cases
      do_cfg(3'd0, 3'd3, 8'd200);
      check("t4_vl_64",    256'(vl),    256'(64));
      check("t4_vtype_03", 256'(vtype), 256'(7'h03));
      do_cfg(3'd3, 3'd0, 8'd3);
      check("t4_vl_1",     256'(vl),    256'(1));
      check("t4_vtype_18", 256'(vtype), 256'(7'h18));
      do_cfg(3'd0, 3'd4, 8'd10);
      check("t4_lmul_vl",   256'(vl),       256'(0));
      check("t4_lmul_vill", 256'(vtype[6]), 256'(1));
      do_cfg(3'd4, 3'd0, 8'd10);
      check("t4_sew_vl",   256'(vl),       256'(0));
      check("t4_sew_vill", 256'(vtype[6]), 256'(1));

      // vl=0: NOP, no beats, no illegal
      do_cfg(3'd2, 3'd2, 8'd0);
      check("t5_vl0", 256'(vl), 256'(0));
      do_instr(4'h4, 5'd8, 5'd12, 5'd16, 32'h3);
      check("t5_no_illegal", 256'(illegal), 256'(0));
      @(posedge clk); #1;
      check("t5_no_beat", 256'(out_valid), 256'(0));
      check("t5_idle",    256'(cfg_ready), 256'(1));

      // SEW=32, LMUL=4, vl=7 under 1,0,0,1 back-pressure
      do_cfg(3'd2, 3'd2, 8'd7);
      check("t6_vl",    256'(vl),    256'(7));
      check("t6_vtype", 256'(vtype), 256'(7'h12));
      for (int b = 0; b < 4; b++)
         push_beat(5'(16 + b), (b == 3) ? 8'h0F : 8'hFF, (b == 3), 5'(8 + b), 5'(12 + b),
                   4'h5, 32'h12345678, 3'd2);
      ready_mode = 1;
      do_instr(4'h5, 5'd8, 5'd12, 5'd16, 32'h12345678);
      wait_idle();
      ready_mode = 0;
      @(posedge clk); #1;

      // reset during beat 2 of an LMUL=8 group
      do_cfg(3'd0, 3'd3, 8'd200);
      push_beat(5'd16, 8'hFF, 1'b0, 5'd0, 5'd8, 4'h7, 32'hCAFE0001, 3'd0);
      push_beat(5'd17, 8'hFF, 1'b0, 5'd1, 5'd9, 4'h7, 32'hCAFE0001, 3'd0);
      do_instr(4'h7, 5'd0, 5'd8, 5'd16, 32'hCAFE0001);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid && out_wa == 5'd18) begin found = 1; break; end
         @(posedge clk); #1;
      end
      check("t7_reach_beat2", 256'(found), 256'(1));
      rst = 1'b0; ready_mode = 2;
      @(posedge clk); #1;
      rst = 1'b1; ready_mode = 0;
      check("t7_out_valid", 256'(out_valid), 256'(0));
      check("t7_vl",        256'(vl),        256'(0));
      check("t7_vtype",     256'(vtype),     256'(7'h40));
      check("t7_idle",      256'(cfg_ready), 256'(1));
      repeat (10) @(posedge clk);
      #1;
      check("t7_no_more_beats", 256'(out_valid), 256'(0));

      check("beats_drained",   256'(exp_q.size()), 256'(0));
      check("illegal_drained", 256'(ill_q.size()), 256'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rvv_group_sequencer.md
Name: rvv_group_sequencer

Overview:
- Parametrised successor to the single-register vector datapath front end. Holds vl/vtype state (vsetvl semantics) and accepts one vector ALU instruction at a time.
- Expands each instruction over its LMUL register group into per-register beats. For each beat it reads the register file, zeroes tail elements past vl, and presents a registered beat (operands, byte enables, write address) to the vALU/writeback stage.
- Uses a valid/ready handshake on both sides. Replaces the combinational grouping/masking path and adds back-pressure and illegal-instruction detection.

Parameters:
- VLEN, 64, bits per vector register; power of two, 64..512.
- ELEN, 64, maximum legal SEW in bits.
- AVL_W, 8, width of the AVL and vl fields.
- XLEN, 32, scalar operand width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- cfg_valid  in  1  vsetvl request
- cfg_ready  out  1  high when state==IDLE
- cfg_sew  in  3  encoded SEW: 0=8, 1=16, 2=32, 3=64
- cfg_lmul  in  3  encoded LMUL: 0=1, 1=2, 2=4, 3=8; all others reserved
- cfg_avl  in  AVL_W  application vector length
- vl  out  AVL_W  current vl
- vtype  out  7  {vill, sew[2:0], lmul[2:0]}
- in_valid  in  1  instruction valid
- in_ready  out  1  (state==IDLE) && !cfg_valid
- in_op  in  4  vALU opcode, passed through
- in_vs1, in_vs2, in_vd  in  5 each  register group base addresses
- in_scalar  in  XLEN  scalar operand, passed through
- rf_raA, rf_raB  out  5 each  register file read addresses (combinational)
- rf_rdA, rf_rdB  in  VLEN each  read data, valid in the same cycle as the address
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts beat
- out_opA, out_opB  out  VLEN each  tail-zeroed operands
- out_scalar  out  XLEN  latched scalar
- out_op  out  4  latched opcode
- out_sew  out  3  SEW for this instruction
- out_wa  out  5  destination register for this beat
- out_be  out  VLEN/8  byte write enables (tail bytes cleared)
- out_last  out  1  final beat of the group
- illegal  out  1  one-cycle pulse: instruction dropped

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, vl=0, vtype=7'b1000000 (vill=1), and all out_* registers zero, including out_valid. illegal=0.
  - Reset mid-instruction aborts all remaining beats. Any beat held on the output is discarded.
- Configuration (cfg_valid && cfg_ready), updated at the next edge:
  - If sew>3, SEW>ELEN, or cfg_lmul>3: vill=1 and vl=0.
  - Otherwise vill=0, sew/lmul are stored, and vl=min(cfg_avl, VLMAX), where VLMAX=(VLEN/SEW)*LMUL.
  - Arithmetic is unsigned and uses a width wide enough to avoid overflow.
  - If cfg_valid and in_valid are both high in IDLE, cfg wins.
- Instruction accept (in_valid && in_ready): latch op, scalar, vs1, vs2, vd, vl and vtype. Later cfg has no effect on the in-flight instruction.
  - Illegal conditions: vill=1, or any of vs1/vs2/vd not a multiple of LMUL.
  - If illegal: illegal=1 on the next cycle, no beats, stay IDLE.
  - If legal with vl==0: accepted as a NOP, no beats, stay IDLE.
  - If legal with vl>0: go to ISSUE with beat counter b=0.
- FSM states:
  - IDLE: waits for cfg or instruction as above.
  - ISSUE: rf_raA=vs1+b and rf_raB=vs2+b. The output register loads when !out_valid || out_ready.
    - On load: out_wa=vd+b and out_last=(b==LMUL-1); then b increments.
    - After the load with b==LMUL-1, go to DRAIN.
  - DRAIN: hold until out_ready; then out_valid=0 and go to IDLE.
    - A new instruction cannot be accepted until DRAIN exits. This makes the first new beat appear no earlier than 2 cycles after the last beat's handshake.
- Latency: the first beat is valid 1 cycle after accept. With out_ready held high, a group issues 1 beat per cycle, so LMUL beats take LMUL consecutive cycles.
- Back-pressure: while out_valid && !out_ready, all out_* signals are stable, b is held, and rf_ra* keep addressing the pending next beat.
- Tail masking: element j of beat b has global index e=b*(VLEN/SEW)+j. If e>=vl:
  - its SEW/8 bytes in out_opA/out_opB are zeroed;
  - the corresponding out_be bits are 0.
  - A beat where every element is tail is still issued, with out_be=0.
- Group addressing: aligned bases guarantee vs+b<=31. No wrap-around logic is needed.

Test Plan:
- Reset, then instruction with vs1=0, vs2=0, vd=0 → illegal pulses 1 cycle later (vill=1), no out_valid, vl=0, vtype=7'h40.
- VLEN=64: cfg sew=1 (16-bit), lmul=1 (LMUL=2), avl=5 → vl=5, vtype=7'h09. Then vs1=2, vs2=4, vd=6 with out_ready=1:
  - beat 0: raA=2, raB=4, out_wa=6, out_be=8'hFF, out_last=0;
  - beat 1: raA=3, raB=5, out_wa=7, out_be=8'h03, out_opA[63:16]=0, out_last=1.
- Same config with vs1=3 → illegal pulse, no beats, in_ready returns high the next cycle.
- cfg sew=0, lmul=3, avl=200 → vl=64 (VLMAX=64). cfg sew=3, lmul=0, avl=3 → vl=1. cfg lmul=4 → vill=1, vl=0.
- LMUL=4 group with out_ready toggling 1,0,0,1,…:
  - exactly 4 beats with out_wa=vd..vd+3 in order;
  - outputs hold stable while stalled;
  - no beat is lost or duplicated.
- Assert rst=0 during beat 2 of an LMUL=8 group → out_valid=0 the next cycle, vl=0, vill=1, FSM IDLE, no further beats.
